// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and pulses bit_tick on the last count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter with a one-entry holding register so consecutive
// frames go out with no idle bits between them.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_byte_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != PAR_NONE);

    tx_state_e  state_q;
    logic [2:0] bit_idx_q;
    logic       hold_full_q, hold_full_d;
    logic       rdy_en_q;
    logic       tx_q;
    logic [7:0] hold_q;
    logic [7:0] shift_q;
    logic       par_q;

    logic bit_tick;
    logic accept;
    logic last_stop;
    logic load;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state_q != ST_IDLE),
        .bit_tick(bit_tick)
    );

    assign accept    = tx_valid && tx_ready;
    assign last_stop = (state_q == ST_STOP) && bit_tick && (bit_idx_q == LAST_STOP);
    // Hold drains into the shifter when idle or on the final stop-bit cycle.
    assign load      = hold_full_q && ((state_q == ST_IDLE) || last_stop);

    always_comb begin
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
        end
    end

    // Payload registers carry no reset; they are qualified by hold_full_q and state_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_q <= tx_data;
        end
        if (load) begin
            shift_q <= hold_q;
            par_q   <= parity_bit(hold_q, PARITY);
        end else if (state_q == ST_DATA && bit_tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            hold_full_q <= 1'b0;
            rdy_en_q    <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            rdy_en_q    <= 1'b1;
            hold_full_q <= hold_full_d;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (hold_full_q) begin
                        state_q   <= ST_START;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            if (HAS_PAR) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        state_q   <= ST_STOP;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (bit_idx_q == LAST_STOP) begin
                            bit_idx_q <= '0;
                            if (hold_full_q) begin
                                state_q <= ST_START;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bit_idx_q <= '0;
                    tx_q      <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ena && rdy_en_q && !hold_full_q;
    assign busy     = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: four parameterisations checked against a frame-schedule model.
module tb_uart_byte_tx;

    localparam int CPB = 4;
    localparam int NI  = 4;
    localparam int PAR_CFG  [NI] = '{0, 1, 2, 1};
    localparam int STOP_CFG [NI] = '{1, 1, 1, 2};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] ena_v;
    logic [NI-1:0] valid_v;
    logic [7:0]    data_v [NI];
    wire  [NI-1:0] tx_v;
    wire  [NI-1:0] rdy_v;
    wire  [NI-1:0] busy_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_byte_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR_CFG[g]),
            .STOP_BITS   (STOP_CFG[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena_v[g]),
            .tx_data (data_v[g]),
            .tx_valid(valid_v[g]),
            .tx_ready(rdy_v[g]),
            .tx      (tx_v[g]),
            .busy    (busy_v[g])
        );
    end

    always #5 clk = ~clk;

    int cyc;
    int vectors;
    int miscompares;
    bit acc_flag;

    // Model: one entry per accepted byte (accept edge, first start-bit edge, byte).
    int         f_acc   [$];
    int         f_start [$];
    logic [7:0] f_dat   [$];

    function automatic int flen(int k);
        return (10 + ((PAR_CFG[k] != 0) ? 1 : 0) + STOP_CFG[k] - 1) * CPB;
    endfunction

    function automatic logic m_tx(int k, int c);
        int pos;
        int ones;
        for (int i = 0; i < f_start.size(); i++) begin
            if (c >= f_start[i] && c < f_start[i] + flen(k)) begin
                pos = (c - f_start[i]) / CPB;
                if (pos == 0) return 1'b0;
                if (pos <= 8) return f_dat[i][pos-1];
                if (pos == 9 && PAR_CFG[k] != 0) begin
                    ones = $countones(f_dat[i]);
                    return (PAR_CFG[k] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
                end
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic m_hold(int c);
        for (int i = 0; i < f_acc.size(); i++) begin
            if (c >= f_acc[i] && c < f_start[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_busy(int k, int c);
        for (int i = 0; i < f_acc.size(); i++) begin
            if (c >= f_acc[i] && c < f_start[i] + flen(k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_ready(int c, logic en);
        return (en === 1'b1) && (c >= 1) && !m_hold(c);
    endfunction

    task automatic m_clear();
        f_acc.delete();
        f_start.delete();
        f_dat.delete();
    endtask

    // Advance one clock, recording an accept in the model when valid meets expected ready.
    task automatic tick(int k);
        int s;
        acc_flag = valid_v[k] && m_ready(cyc, ena_v[k]);
        if (acc_flag) begin
            s = cyc + 2;
            if (f_start.size() > 0 && f_start[$] + flen(k) > s) s = f_start[$] + flen(k);
            f_acc.push_back(cyc + 1);
            f_start.push_back(s);
            f_dat.push_back(data_v[k]);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        valid_v = '0;
        ena_v   = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_v = '0;
        ena_v   = '1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (tx_v[k] !== 1'b1) begin
                miscompares++; $display("FAIL reset_tx k=%0d got=%b exp=1", k, tx_v[k]);
            end
            vectors++;
            if (rdy_v[k] !== 1'b0) begin
                miscompares++; $display("FAIL reset_ready k=%0d got=%b exp=0", k, rdy_v[k]);
            end
            vectors++;
            if (busy_v[k] !== 1'b0) begin
                miscompares++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, busy_v[k]);
            end
        end
        rst_n = 1'b1;
        m_clear();
        cyc = 0;
        #1;
        vectors++;
        if (rdy_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL release_ready_pre got=%b exp=0", rdy_v[0]);
        end
        tick(0);
        vectors++;
        if (rdy_v[0] !== 1'b1) begin
            miscompares++; $display("FAIL release_ready_post got=%b exp=1", rdy_v[0]);
        end
        vectors++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL release_idle tx=%b busy=%b exp tx=1 busy=0", tx_v[0], busy_v[0]);
        end
    endtask

    task automatic test_single();
        int n = -1;
        do_reset();
        tick(0);
        data_v[0] = 8'h55;
        for (int i = 0; i < 50; i++) begin
            vectors++;
            if (tx_v[0] !== m_tx(0, cyc)) begin
                miscompares++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", cyc, tx_v[0], m_tx(0, cyc));
            end
            vectors++;
            if (busy_v[0] !== m_busy(0, cyc) || rdy_v[0] !== m_ready(cyc, ena_v[0])) begin
                miscompares++;
                $display("FAIL single_ctl cyc=%0d busy=%b ready=%b exp busy=%b ready=%b",
                         cyc, busy_v[0], rdy_v[0], m_busy(0, cyc), m_ready(cyc, ena_v[0]));
            end
            if (n >= 0 && cyc == n + 1) begin
                vectors++;
                if (tx_v[0] !== 1'b0) begin
                    miscompares++; $display("FAIL single_latency got=%b exp=0", tx_v[0]);
                end
            end
            if (n >= 0 && (cyc == n + 40 || cyc == n + 41)) begin
                vectors++;
                if (busy_v[0] !== (cyc == n + 40)) begin
                    miscompares++; $display("FAIL single_busy_fall cyc=%0d got=%b exp=%b", cyc, busy_v[0], cyc == n + 40);
                end
            end
            valid_v[0] = (i == 0);
            tick(0);
            if (acc_flag) n = cyc;
        end
        valid_v[0] = 1'b0;
    endtask

    task automatic test_parity();
        for (int t = 0; t < 2; t++) begin
            int   k    = t + 1;
            int   n    = -1;
            logic epar = (t == 1);
            do_reset();
            tick(k);
            data_v[k] = (t == 1) ? 8'hA5 : 8'h55;
            for (int i = 0; i < 55; i++) begin
                vectors++;
                if (tx_v[k] !== m_tx(k, cyc) || busy_v[k] !== m_busy(k, cyc)) begin
                    miscompares++;
                    $display("FAIL parity_frame k=%0d cyc=%0d tx=%b busy=%b exp tx=%b busy=%b",
                             k, cyc, tx_v[k], busy_v[k], m_tx(k, cyc), m_busy(k, cyc));
                end
                if (n >= 0 && cyc >= n + 37 && cyc <= n + 40) begin
                    vectors++;
                    if (tx_v[k] !== epar) begin
                        miscompares++; $display("FAIL parity_bit k=%0d cyc=%0d got=%b exp=%b", k, cyc, tx_v[k], epar);
                    end
                end
                if (n >= 0 && (cyc == n + 44 || cyc == n + 45)) begin
                    vectors++;
                    if (busy_v[k] !== (cyc == n + 44)) begin
                        miscompares++; $display("FAIL parity_len k=%0d cyc=%0d got=%b exp=%b", k, cyc, busy_v[k], cyc == n + 44);
                    end
                end
                valid_v[k] = (i == 0);
                tick(k);
                if (acc_flag) n = cyc;
            end
            valid_v[k] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int n1 = -1;
        int n2 = -1;
        do_reset();
        tick(0);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h01;
        for (int i = 0; i < 100; i++) begin
            vectors++;
            if (tx_v[0] !== m_tx(0, cyc) || busy_v[0] !== m_busy(0, cyc) || rdy_v[0] !== m_ready(cyc, ena_v[0])) begin
                miscompares++;
                $display("FAIL b2b_frame cyc=%0d tx=%b busy=%b ready=%b exp %b %b %b", cyc, tx_v[0], busy_v[0],
                         rdy_v[0], m_tx(0, cyc), m_busy(0, cyc), m_ready(cyc, ena_v[0]));
            end
            if (n1 >= 0 && (cyc == n1 + 40 || cyc == n1 + 41)) begin
                vectors++;
                if (tx_v[0] !== (cyc == n1 + 40)) begin
                    miscompares++; $display("FAIL b2b_gap cyc=%0d got=%b exp=%b", cyc, tx_v[0], cyc == n1 + 40);
                end
            end
            if (n2 >= 0 && cyc < n1 + 41) begin
                vectors++;
                if (rdy_v[0] !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_ready_low cyc=%0d got=%b exp=0", cyc, rdy_v[0]);
                end
            end
            tick(0);
            if (acc_flag) begin
                if (n1 < 0) begin
                    n1 = cyc;
                    data_v[0] = 8'h80;
                end else begin
                    n2 = cyc;
                    valid_v[0] = 1'b0;
                end
            end
        end
        valid_v[0] = 1'b0;
    endtask

    task automatic test_random_stream();
        for (int t = 0; t < 2; t++) begin
            int k = (t == 0) ? 0 : 3;
            do_reset();
            for (int i = 0; i < 500; i++) begin
                vectors++;
                if (tx_v[k] !== m_tx(k, cyc) || busy_v[k] !== m_busy(k, cyc) || rdy_v[k] !== m_ready(cyc, ena_v[k])) begin
                    miscompares++;
                    $display("FAIL stream k=%0d cyc=%0d tx=%b busy=%b ready=%b exp %b %b %b", k, cyc, tx_v[k],
                             busy_v[k], rdy_v[k], m_tx(k, cyc), m_busy(k, cyc), m_ready(cyc, ena_v[k]));
                end
                valid_v[k] = (i < 400) && ($urandom_range(0, 2) != 0);
                data_v[k]  = 8'($urandom);
                tick(k);
            end
            valid_v[k] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int n = -1;
        do_reset();
        tick(0);
        data_v[0] = 8'hFF;
        for (int i = 0; i < 40 && !(n >= 0 && cyc >= n + 18); i++) begin
            vectors++;
            if (tx_v[0] !== m_tx(0, cyc) || busy_v[0] !== m_busy(0, cyc)) begin
                miscompares++; $display("FAIL midrst_pre cyc=%0d tx=%b busy=%b exp %b %b", cyc, tx_v[0], busy_v[0], m_tx(0, cyc), m_busy(0, cyc));
            end
            valid_v[0] = (i == 0);
            tick(0);
            if (acc_flag) n = cyc;
        end
        valid_v[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL midrst_async tx=%b busy=%b ready=%b exp 1 0 0", tx_v[0], busy_v[0], rdy_v[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            vectors++;
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
                miscompares++; $display("FAIL midrst_after cyc=%0d tx=%b busy=%b exp 1 0", cyc, tx_v[0], busy_v[0]);
            end
            tick(0);
        end
        // Reset during a start bit, where the line is low.
        n = -1;
        data_v[0] = 8'h00;
        for (int i = 0; i < 10 && !(n >= 0 && cyc >= n + 2); i++) begin
            valid_v[0] = (i == 0);
            tick(0);
            if (acc_flag) n = cyc;
        end
        valid_v[0] = 1'b0;
        vectors++;
        if (tx_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL midrst_start_low got=%b exp=0", tx_v[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL midrst_start_async tx=%b busy=%b exp 1 0", tx_v[0], busy_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        cyc = 0;
    endtask

    task automatic test_ena_drop();
        int n1 = -1;
        int n2 = -1;
        do_reset();
        tick(1);
        valid_v[1] = 1'b1;
        data_v[1]  = 8'($urandom);
        for (int i = 0; i < 120; i++) begin
            vectors++;
            if (tx_v[1] !== m_tx(1, cyc) || busy_v[1] !== m_busy(1, cyc) || rdy_v[1] !== m_ready(cyc, ena_v[1])) begin
                miscompares++;
                $display("FAIL ena_frame cyc=%0d tx=%b busy=%b ready=%b exp %b %b %b", cyc, tx_v[1], busy_v[1],
                         rdy_v[1], m_tx(1, cyc), m_busy(1, cyc), m_ready(cyc, ena_v[1]));
            end
            if (ena_v[1] === 1'b0) begin
                vectors++;
                if (rdy_v[1] !== 1'b0) begin
                    miscompares++; $display("FAIL ena_ready cyc=%0d got=%b exp=0", cyc, rdy_v[1]);
                end
            end
            if (n1 >= 0 && (cyc == n1 + 45 || cyc == n1 + 88 || cyc == n1 + 89)) begin
                vectors++;
                if ({tx_v[1], busy_v[1]} !== ((cyc == n1 + 45) ? 2'b01 : (cyc == n1 + 88) ? 2'b11 : 2'b10)) begin
                    miscompares++; $display("FAIL ena_second_frame cyc=%0d tx=%b busy=%b", cyc, tx_v[1], busy_v[1]);
                end
            end
            if (n1 >= 0 && cyc == n1 + 12) ena_v[1] = 1'b0;
            if (ena_v[1] === 1'b0) begin
                valid_v[1] = ($urandom_range(0, 1) == 1);
                data_v[1]  = 8'($urandom);
            end
            tick(1);
            if (acc_flag) begin
                if (n1 < 0) begin
                    n1 = cyc;
                    data_v[1] = 8'($urandom);
                end else if (n2 < 0) begin
                    n2 = cyc;
                    valid_v[1] = 1'b0;
                end
            end
        end
        vectors++;
        if (f_acc.size() != 2) begin
            miscompares++; $display("FAIL ena_accept_count got=%0d exp=2", f_acc.size());
        end
        valid_v[1] = 1'b0;
        ena_v[1]   = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        ena_v       = '1;
        valid_v     = '0;
        for (int k = 0; k < NI; k++) data_v[k] = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        test_ena_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
